// File: rtl/seq_pattern_tx.sv
// ---------------------------------------------------------------------------
// seq_pattern_tx
//   Serial frame transmitter. On an accepted start, the block sends an 8-bit
//   sync word MSB-first, followed by the 8-bit payload latched at start,
//   MSB-first. When SEQ_TX_PARITY_EN is defined, it then sends one even-parity
//   bit (XOR of the latched payload).
//
//   Optional feature macro: SEQ_TX_PARITY_EN (adds the parity bit; frame 17 bits)
//   Default build:          no parity (frame 16 bits)
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   frame request, honoured only while idle (busy=0)
//   payload  in   [7:0] frame data, captured on an accepted start
//   dataout  out  registered serial bit
//   valid    out  registered, high while dataout carries a frame bit
//   busy     out  registered, high for every frame bit
//   done     out  registered one-cycle pulse in the cycle after the last bit
//
// Parameters
//   SYNC_WORD  sync pattern sent at the head of every frame
//
// State table
//   state    | meaning
//   ---------+-----------------------------------------------------
//   S_IDLE   | no frame; outputs low; start accepted here
//   S_SYNC   | dataout = SYNC_WORD[idx], idx counts 7 down to 0
//   S_DATA   | dataout = latched payload[idx], idx counts 7 down to 0
//   S_PARITY | dataout = ^latched payload (SEQ_TX_PARITY_EN only)
// ---------------------------------------------------------------------------
module seq_pattern_tx #(
  parameter logic [7:0] SYNC_WORD = 8'b10110101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] payload,
  output logic       dataout,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SYNC   = 2'd1;
  localparam logic [1:0] S_DATA   = 2'd2;
`ifdef SEQ_TX_PARITY_EN
  localparam logic [1:0] S_PARITY = 2'd3;
`endif

  logic [1:0] state_q, state_d;
  logic [2:0] idx_q,   idx_d;
  logic [7:0] pl_q,    pl_d;
  logic       dout_q,  dout_d;
  logic       valid_q, valid_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;

  // Next-state logic. The state and index describe the bit that goes on
  // dataout in the following cycle. This gives one cycle of latency from the
  // start edge and keeps every output a plain flop.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pl_d    = pl_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SYNC;
          idx_d   = 3'd7;
          pl_d    = payload;
        end
      end

      // The index wraps from 0 to 7 on the same edge that moves SYNC to DATA.
      S_SYNC: begin
        idx_d = idx_q - 3'd1;
        if (idx_q == 3'd0) begin
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        idx_d = idx_q - 3'd1;
        if (idx_q == 3'd0) begin
`ifdef SEQ_TX_PARITY_EN
          state_d = S_PARITY;
          idx_d   = 3'd0;
`else
          state_d = S_IDLE;
          idx_d   = 3'd0;
          done_d  = 1'b1;
`endif
        end
      end

`ifdef SEQ_TX_PARITY_EN
      S_PARITY: begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
        done_d  = 1'b1;
      end
`endif

      default: begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state they describe.
  always_comb begin
    dout_d  = 1'b0;
    valid_d = 1'b1;

    case (state_d)
      S_SYNC:   dout_d = SYNC_WORD[idx_d];
      S_DATA:   dout_d = pl_d[idx_d];
`ifdef SEQ_TX_PARITY_EN
      S_PARITY: dout_d = ^pl_d;
`endif
      default:  valid_d = 1'b0;
    endcase

    busy_d = valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      pl_q    <= 8'd0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pl_q    <= pl_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dataout = dout_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_tx
//   Self-checking bench for seq_pattern_tx. It runs a table of known frames,
//   hand-written corner sequences, and a randomized phase. A queue-based
//   frame model checks every cycle against the DUT.
// ---------------------------------------------------------------------------
module tb_seq_pattern_tx;

  localparam logic [7:0] SYNC = 8'b10110101;
`ifdef SEQ_TX_PARITY_EN
  localparam int FL = 17;
`else
  localparam int FL = 16;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] payload = 8'h00;
  logic       dataout, valid, busy, done;

  int errors = 0;
  int checks = 0;

  seq_pattern_tx #(.SYNC_WORD(SYNC)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .payload (payload),
    .dataout (dataout),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Reference model: one frame is a queue of bits. While a frame is being
  // sent, the model pops one bit per cycle. After the queue empties, it holds
  // one done cycle. Only an idle (non-valid) cycle can accept a start.
  bit   mq[$];
  logic m_dout = 1'b0, m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_dout = 1'b0; m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    end else if (m_valid) begin
      if (mq.size() > 0) begin
        m_dout = mq.pop_front();
        m_done = 1'b0;
      end else begin
        m_dout = 1'b0; m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b1;
      end
    end else if (start) begin
      mq.delete();
      for (int i = 7; i >= 0; i--) mq.push_back(SYNC[i]);
      for (int i = 7; i >= 0; i--) mq.push_back(payload[i]);
`ifdef SEQ_TX_PARITY_EN
      mq.push_back(^payload);
`endif
      m_dout = mq.pop_front();
      m_valid = 1'b1; m_busy = 1'b1; m_done = 1'b0;
    end else begin
      m_dout = 1'b0; m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("model_dataout", {31'd0, dataout}, {31'd0, m_dout});
    chk("model_valid",   {31'd0, valid},   {31'd0, m_valid});
    chk("model_busy",    {31'd0, busy},    {31'd0, m_busy});
    chk("model_done",    {31'd0, done},    {31'd0, m_done});
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_outs"}, {28'd0, dataout, valid, busy, done}, 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0) && (n < 64)) begin
      tick();
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // This task sends one frame and compares the collected stream with expf.
  // When inj is in range, start is pulsed with payload FF while dataout
  // shows frame bit inj.
  task automatic run_frame(input logic [7:0] pl, input logic [FL-1:0] expf,
                           input int inj, input string nm);
    logic [FL-1:0] got;
    got = '0;
    wait_idle();
    payload = pl;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int k = 0; k < FL; k++) begin
      chk({nm, "_valid"}, {31'd0, valid}, 32'd1);
      got[FL-1-k] = dataout;
      if (k == inj) begin
        start   = 1'b1;
        payload = 8'hFF;
      end else if (k == inj + 1) begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk({nm, "_stream"}, {{(32-FL){1'b0}}, got}, {{(32-FL){1'b0}}, expf});
    chk({nm, "_done"}, {29'd0, done, valid, dataout}, 32'd4);
    tick();
    chk({nm, "_done_once"}, {31'd0, done}, 32'd0);
  endtask

  typedef struct {
    logic [7:0]    pl;
    logic [FL-1:0] frame;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int dn, vz;

`ifdef SEQ_TX_PARITY_EN
    tbl.push_back('{8'hA5, {16'hB5A5, 1'b0}});
    tbl.push_back('{8'h00, {16'hB500, 1'b0}});
    tbl.push_back('{8'hFF, {16'hB5FF, 1'b0}});
    tbl.push_back('{8'h3C, {16'hB53C, 1'b0}});
    tbl.push_back('{8'h07, {16'hB507, 1'b1}});
    tbl.push_back('{8'h03, {16'hB503, 1'b0}});
    tbl.push_back('{8'h80, {16'hB580, 1'b1}});
`else
    tbl.push_back('{8'hA5, 16'hB5A5});
    tbl.push_back('{8'h00, 16'hB500});
    tbl.push_back('{8'hFF, 16'hB5FF});
    tbl.push_back('{8'h3C, 16'hB53C});
    tbl.push_back('{8'h01, 16'hB501});
`endif

    // Reset is held for 2 cycles with start high.
    rst = 1'b1; start = 1'b1; payload = 8'hA5;
    repeat (2) begin
      tick();
      chk_all_zero("reset");
    end
    rst = 1'b0; start = 1'b0;
    tick();
    chk_all_zero("after_reset");

    // Frames from the table.
    foreach (tbl[i]) run_frame(tbl[i].pl, tbl[i].frame, -10, "table");

    // A start during a frame is ignored, and no frame is queued.
    run_frame(8'hA5, tbl[0].frame, 5, "ignore_busy");
    payload = 8'h00;
    repeat (3) begin
      tick();
      chk("ignore_busy_no_queue", {30'd0, valid, done}, 32'd0);
    end

    // With start held high, frames repeat with one gap cycle each.
    wait_idle();
    payload = 8'hA5; start = 1'b1; dn = 0; vz = 0;
    for (int i = 0; i < 3 * (FL + 1); i++) begin
      tick();
      if (done === 1'b1) dn++;
      if (valid !== 1'b1) vz++;
    end
    start = 1'b0;
    chk("b2b_done_count", dn, 32'd3);
    chk("b2b_gap_count", vz, 32'd3);
    tick();

    // Reset while the DUT sends DATA bit 3 (frame bit 12).
    wait_idle();
    payload = 8'h3C; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    chk("midrst_valid_before", {31'd0, valid}, 32'd1);
    rst = 1'b1;
    tick();
    chk_all_zero("midrst");
    rst = 1'b0;
    repeat (3) begin
      tick();
      chk("midrst_no_done", {30'd0, valid, done}, 32'd0);
    end
    run_frame(tbl[0].pl, tbl[0].frame, -10, "after_midrst");

    // Randomized phase, checked against the model each cycle.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 63) == 0);
      start   = ($urandom_range(0, 3) == 0);
      payload = 8'($urandom);
      tick();
    end
    rst = 1'b0; start = 1'b0;
    repeat (FL + 3) tick();
    chk("final_idle", {28'd0, dataout, valid, busy, done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 The block SHALL have parameter SYNC_WORD, default 8'b10110101, the sync word sent MSB-first at the start of every frame.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: frame request, sampled only while busy=0.
REQ-005 The block SHALL have port payload, input, 8 bits: frame data, captured on an accepted start.
REQ-006 The block SHALL have port dataout, output, 1 bit: serial bit stream, registered.
REQ-007 The block SHALL have port valid, output, 1 bit: high while dataout carries a frame bit, registered.
REQ-008 The block SHALL have port busy, output, 1 bit: high from the cycle after an accepted start through the last frame bit, registered.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last frame bit, registered.

Function
REQ-010 The FSM SHALL have states IDLE, SYNC, DATA, and PARITY (PARITY only with the macro in REQ-022).
REQ-011 In IDLE with start=1 at a rising edge, the block SHALL latch payload and enter SYNC with bit index 7.
REQ-012 The first frame bit SHALL appear on dataout with valid=1 in the cycle after the start edge, giving 1 cycle of latency.
REQ-013 SYNC SHALL output SYNC_WORD[7] down to SYNC_WORD[0], one bit per cycle for 8 cycles, then enter DATA with index 7.
REQ-014 DATA SHALL output the latched payload[7] down to payload[0] for 8 cycles; the latched copy SHALL be unaffected by later payload changes.
REQ-015 After DATA bit 0, the block SHALL go to PARITY if the macro in REQ-022 is defined, otherwise to IDLE.
REQ-016 In the first cycle after the last frame bit, the block SHALL drive valid=0, busy=0, dataout=0 and done=1 for exactly one cycle.
REQ-017 While busy=1, start SHALL be ignored, with no queuing and no effect on the frame in progress.
REQ-018 A start asserted in the same cycle that done=1 SHALL be accepted, so the next frame's first bit follows with exactly one idle cycle between frames.
REQ-019 In IDLE, the block SHALL drive dataout=0 and valid=0.
REQ-020 The bit index SHALL be a 3-bit down-counter, and its wrap from 0 SHALL coincide with the state change.

Reset
REQ-021 With rst=1 at a rising edge, including mid-frame, the block SHALL enter IDLE, clear the index and latched payload, set dataout=0, valid=0, busy=0, done=0, emit no done pulse, and ignore start in that cycle.

Configuration
REQ-022 The block SHALL support macro SEQ_TX_PARITY_EN:
- Defined: after DATA, one PARITY cycle outputs the even parity (XOR) of the latched payload with valid=1; the frame is 17 bits.
- Undefined: no PARITY state; the frame is 16 bits.

Verification
REQ-023 Reset: hold rst 2 cycles with start=1 -> dataout=0, valid=0, busy=0, done=0 throughout and after.
REQ-024 Single frame, payload=8'hA5, macro off -> valid high 16 cycles, dataout=1011010110100101, done on cycle 17 after start.
REQ-025 Ignore while busy: start pulse at frame bit 5 with payload=8'hFF -> stream unchanged (payload bits still 10100101), exactly one done pulse.
REQ-026 Back-to-back: start held high continuously -> frames repeat with exactly one valid=0 cycle between them, one done per frame.
REQ-027 Mid-frame reset: rst at DATA bit 3 -> next cycle all outputs 0, no done, a new start produces a full frame beginning with sync bit 1.
REQ-028 Parity, macro on: payload=8'h07 -> bit 17 = 1, and payload=8'h03 -> bit 17 = 0; done one cycle after bit 17.
